// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch/decode decoupling queue: reset vector,
// NOP encoding and the bit layout of one queue entry.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int FQ_ENTRY_W   = 96;
  localparam int FQ_INSTR_LSB = 64;
  localparam int FQ_PC_LSB    = 32;
  localparam int FQ_PC4_LSB   = 0;

endpackage

// File: rtl/fq_storage.sv
// DEPTH x FQ_ENTRY_W register array: one synchronous write port and one
// combinational read port, cleared by the asynchronous reset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [FQ_ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [FQ_ENTRY_W-1:0] rdata
);

  logic [DEPTH-1:0][FQ_ENTRY_W-1:0] mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
        mem[g] <= '0;
      else if (we && (waddr == PTR_W'(g)))
        mem[g] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO: buffers {instr, PC, PC+4}, presents the oldest entry
// to decode, stalls fetch one entry early and drops everything on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Enq_Valid_IN,
  input  logic [31:0]      Instr1_IN,
  input  logic [31:0]      Instr_PC_IN,
  input  logic [31:0]      Instr_PC_Plus4_IN,
  input  logic             Flush_IN,
  input  logic             Deq_Ready_IN,
  output logic             STALL_2IF,
  output logic             Valid_OUT,
  output logic [31:0]      Instr1_OUT,
  output logic [31:0]      Instr_PC_OUT,
  output logic [31:0]      Instr_PC_Plus4_OUT,
  output logic [PTR_W:0]   Count_OUT,
  output logic             Overflow_ERR
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_HIGH = (PTR_W+1)'(DEPTH-1);

  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W:0]        count;
  logic                  empty, full, enq, deq, ovf;
  logic [FQ_ENTRY_W-1:0] wdata, rdata;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign deq   = Deq_Ready_IN && !empty && !Flush_IN;
  assign enq   = Enq_Valid_IN && !Flush_IN && (!full || deq);
  assign ovf   = Enq_Valid_IN && !Flush_IN && full && !deq;

  always_comb begin
    wdata = '0;
    wdata[FQ_INSTR_LSB +: 32] = Instr1_IN;
    wdata[FQ_PC_LSB    +: 32] = Instr_PC_IN;
    wdata[FQ_PC4_LSB   +: 32] = Instr_PC_Plus4_IN;
  end

  fq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (enq),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      Overflow_ERR <= 1'b0;
    end else if (Flush_IN) begin
      // redirect wins; stale storage is unreachable once count is zero
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + 1'b1;
      if (enq) tail <= tail + 1'b1;
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      if (ovf) Overflow_ERR <= 1'b1;
    end
  end

  // one-entry margin covers the instruction already in fetch's output register
  assign STALL_2IF          = (count >= CNT_HIGH);
  assign Valid_OUT          = !empty;
  assign Instr1_OUT         = empty ? NOP_INSTR : rdata[FQ_INSTR_LSB +: 32];
  assign Instr_PC_OUT       = empty ? 32'h0 : rdata[FQ_PC_LSB +: 32];
  assign Instr_PC_Plus4_OUT = empty ? 32'h0 : rdata[FQ_PC4_LSB +: 32];
  assign Count_OUT          = count;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RESET) begin
      if (Flush_IN)
        $display("fetch_queue: flush, count %0d -> 0", count);
      if (deq)
        $display("fetch_queue: deq pc %h count %0d", Instr_PC_OUT, count);
      if (enq)
        $display("fetch_queue: enq pc %h count %0d", Instr_PC_IN, count);
      if (ovf)
        $display("fetch_queue: queue full, enqueue of pc %h dropped", Instr_PC_IN);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: hand-computed expectations plus a small
// PC scoreboard for in-order checks across the pointer wrap.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Enq_Valid_IN, Flush_IN, Deq_Ready_IN;
  logic [31:0] Instr1_IN, Instr_PC_IN, Instr_PC_Plus4_IN;
  logic        STALL_2IF, Valid_OUT, Overflow_ERR;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
  logic [3:0]  Count_OUT;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Enq_Valid_IN       (Enq_Valid_IN),
    .Instr1_IN          (Instr1_IN),
    .Instr_PC_IN        (Instr_PC_IN),
    .Instr_PC_Plus4_IN  (Instr_PC_Plus4_IN),
    .Flush_IN           (Flush_IN),
    .Deq_Ready_IN       (Deq_Ready_IN),
    .STALL_2IF          (STALL_2IF),
    .Valid_OUT          (Valid_OUT),
    .Instr1_OUT         (Instr1_OUT),
    .Instr_PC_OUT       (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
    .Count_OUT          (Count_OUT),
    .Overflow_ERR       (Overflow_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc);
    Instr1_IN         = ~pc;
    Instr_PC_IN       = pc;
    Instr_PC_Plus4_IN = pc + 32'd4;
  endtask

  task automatic enq(input logic [31:0] pc);
    drive(pc);
    Enq_Valid_IN = 1'b1;
    tick();
    Enq_Valid_IN = 1'b0;
  endtask

  task automatic chk_head(input string tag);
    chk({tag, "_valid"}, {31'd0, Valid_OUT}, 32'd1);
    chk({tag, "_pc"},    Instr_PC_OUT,       sb[0]);
    chk({tag, "_pc4"},   Instr_PC_Plus4_OUT, sb[0] + 32'd4);
    chk({tag, "_instr"}, Instr1_OUT,         ~sb[0]);
  endtask

  initial begin
    RESET = 1'b0;
    Enq_Valid_IN = 1'b0; Flush_IN = 1'b0; Deq_Ready_IN = 1'b0;
    drive(32'h0);
    #1;
    chk("rst_count", 32'(Count_OUT), 32'd0);
    chk("rst_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("rst_stall", {31'd0, STALL_2IF}, 32'd0);
    chk("rst_ovf",   {31'd0, Overflow_ERR}, 32'd0);
    chk("rst_instr", Instr1_OUT, 32'd0);
    tick(); tick();
    RESET = 1'b1;
    tick();

    // 1: three enqueues, no dequeue
    for (int i = 0; i < 3; i++) begin
      enq(32'hBFC00000 + 32'(4*i));
      sb.push_back(32'hBFC00000 + 32'(4*i));
    end
    chk("t1_count", 32'(Count_OUT), 32'd3);
    chk_head("t1_head");
    chk("t1_stall", {31'd0, STALL_2IF}, 32'd0);

    // 2: fill to 7 (stall), 8 (full), 9th dropped
    for (int i = 3; i < 6; i++) begin
      enq(32'hBFC00000 + 32'(4*i));
      sb.push_back(32'hBFC00000 + 32'(4*i));
    end
    chk("t2_stall6", {31'd0, STALL_2IF}, 32'd0);
    enq(32'hBFC00018); sb.push_back(32'hBFC00018);
    chk("t2_count7", 32'(Count_OUT), 32'd7);
    chk("t2_stall7", {31'd0, STALL_2IF}, 32'd1);
    enq(32'hBFC0001C); sb.push_back(32'hBFC0001C);
    chk("t2_count8", 32'(Count_OUT), 32'd8);
    chk("t2_ovf8",   {31'd0, Overflow_ERR}, 32'd0);
    enq(32'hBFC00020);
    chk("t2_count9", 32'(Count_OUT), 32'd8);
    chk("t2_ovf9",   {31'd0, Overflow_ERR}, 32'd1);
    chk_head("t2_head");

    // 3: full queue, simultaneous enq+deq, then in-order drain across the wrap
    for (int i = 0; i < 8; i++) begin
      chk_head("t3_swap");
      drive(32'h80000000 + 32'(16*i));
      Enq_Valid_IN = 1'b1; Deq_Ready_IN = 1'b1;
      tick();
      void'(sb.pop_front());
      sb.push_back(32'h80000000 + 32'(16*i));
      chk("t3_count", 32'(Count_OUT), 32'd8);
    end
    Enq_Valid_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_head("t3_drain");
      tick();
      void'(sb.pop_front());
    end
    Deq_Ready_IN = 1'b0;
    chk("t3_empty", 32'(Count_OUT), 32'd0);
    chk("t3_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("t3_ovf",   {31'd0, Overflow_ERR}, 32'd1);

    // 4: flush with concurrent enq and deq
    for (int i = 0; i < 5; i++) enq(32'h10000000 + 32'(4*i));
    chk("t4_count5", 32'(Count_OUT), 32'd5);
    drive(32'h20000000);
    Flush_IN = 1'b1; Enq_Valid_IN = 1'b1; Deq_Ready_IN = 1'b1;
    tick();
    Flush_IN = 1'b0; Enq_Valid_IN = 1'b0; Deq_Ready_IN = 1'b0;
    chk("t4_count", 32'(Count_OUT), 32'd0);
    chk("t4_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("t4_instr", Instr1_OUT, 32'd0);
    chk("t4_stall", {31'd0, STALL_2IF}, 32'd0);
    enq(32'h00400000); sb.push_back(32'h00400000);
    chk("t4_count1", 32'(Count_OUT), 32'd1);
    chk_head("t4_head");
    Deq_Ready_IN = 1'b1;
    tick();
    void'(sb.pop_front());

    // 5: deq-ready held while empty
    tick(); tick();
    chk("t5_idle", 32'(Count_OUT), 32'd0);
    enq(32'h00400010); sb.push_back(32'h00400010);
    chk("t5_count1", 32'(Count_OUT), 32'd1);
    chk_head("t5_head");
    tick();
    void'(sb.pop_front());
    chk("t5_count0", 32'(Count_OUT), 32'd0);
    chk("t5_valid",  {31'd0, Valid_OUT}, 32'd0);
    Deq_Ready_IN = 1'b0;

    // 6: async reset between edges with entries and sticky error
    for (int i = 0; i < 4; i++) enq(32'h30000000 + 32'(4*i));
    chk("t6_count4", 32'(Count_OUT), 32'd4);
    chk("t6_ovf",    {31'd0, Overflow_ERR}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("t6_count", 32'(Count_OUT), 32'd0);
    chk("t6_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("t6_ovf0",  {31'd0, Overflow_ERR}, 32'd0);
    chk("t6_instr", Instr1_OUT, 32'd0);
    chk("t6_pc",    Instr_PC_OUT, 32'd0);
    chk("t6_pc4",   Instr_PC_Plus4_OUT, 32'd0);
    chk("t6_stall", {31'd0, STALL_2IF}, 32'd0);
    #1 RESET = 1'b1;
    tick();
    chk("t6_after", 32'(Count_OUT), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and decode.
- Captures each fetched instruction with its PC and PC+4, and presents the oldest entry to decode via a valid/ready handshake.
- Back-pressures fetch via its STALL input.
- Discards all buffered work on a PC redirect (branch or flush).

Parameters:
DEPTH, 8, number of entries; must be a power of 2, minimum 4.
PTR_W, 3, log2(DEPTH); head/tail pointer width.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
Enq_Valid_IN  in  1  one-cycle pulse per new instruction produced by fetch.
Instr1_IN  in  32  fetched instruction word.
Instr_PC_IN  in  32  address of the fetched instruction.
Instr_PC_Plus4_IN  in  32  address of the following instruction.
Flush_IN  in  1  redirect; same signal that drives fetch's Request_Alt_PC.
Deq_Ready_IN  in  1  decode consumes the head entry this cycle.
STALL_2IF  out  1  freeze fetch; drives fetch STALL.
Valid_OUT  out  1  head entry valid.
Instr1_OUT  out  32  head instruction; 0 (NOP) when empty.
Instr_PC_OUT  out  32  head PC; 0 when empty.
Instr_PC_Plus4_OUT  out  32  head PC+4; 0 when empty.
Count_OUT  out  PTR_W+1  number of occupied entries, 0..DEPTH.
Overflow_ERR  out  1  sticky; set when an enqueue is dropped because the queue is full.

Behaviour:
- Reset (RESET low, async):
  - head=tail=0, count=0, Overflow_ERR=0, all storage cleared to 0.
  - Hence Valid_OUT=0, data outputs=0, STALL_2IF=0.
- Storage: circular buffer of {Instr1, PC, PC+4}, 96 bits per entry.
  - Pointers are PTR_W bits and wrap modulo DEPTH.
  - Count is kept separately; full = (count==DEPTH), empty = (count==0).
- Head outputs are combinational reads of storage[head], gated by !empty.
  - Zero latency from the head register; an enqueued entry becomes visible the cycle after its enqueue edge.
- Dequeue on an edge: deq = Deq_Ready_IN && !empty && !Flush_IN.
  - head <= head+1.
  - Deq_Ready_IN while empty is ignored.
- Enqueue on an edge: enq = Enq_Valid_IN && !Flush_IN && (!full || deq).
  - Write storage[tail], then tail <= tail+1.
  - Simultaneous enq+deq: count unchanged, allowed even when full.
- Overflow: Enq_Valid_IN && !Flush_IN && full && !deq.
  - The entry is dropped, Overflow_ERR <= 1 (sticky until reset), and a $display diagnostic is emitted.
- STALL_2IF is combinational: STALL_2IF = (count >= DEPTH-1).
  - The one-entry margin absorbs the instruction fetch already has in its output register when the stall asserts.
  - In normal operation overflow is therefore unreachable.
- Flush_IN (highest priority):
  - On the edge: head=tail=0, count=0.
  - A concurrent enqueue or dequeue is discarded.
  - Storage contents need not be cleared.
  - The cycle after the flush: Valid_OUT=0, STALL_2IF=0.
- Flush while full: same as above; STALL_2IF deasserts in the following cycle.
- Reset mid-operation: immediate return to reset state regardless of CLK.
- Count update: count <= count + enq - deq, computed in PTR_W+1 bits with no wrap.
- Diagnostics: $display on every enqueue, dequeue and flush, giving PC and count.

Decomposition:
- Shared package (header constants):
  - RESET_PC = 32'hBFC00000
  - NOP_INSTR = 32'h0
  - FQ_ENTRY_W = 96
  - field offsets for Instr, PC and PC+4 within an entry.
- One sub-module, fq_storage: DEPTH x FQ_ENTRY_W register array.
  - Synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
  - Async reset to 0.
- All pointer, count and flag logic stays in fetch_queue.

Test Plan:
1. Reset, then enqueue PCs 0xBFC00000, 0xBFC00004 and 0xBFC00008 with Deq_Ready_IN=0 -> Count_OUT=3; head PC=0xBFC00000 and head PC+4=0xBFC00004.
2. Enqueue 7 entries with no dequeue (DEPTH=8) -> STALL_2IF=1 once count=7; an 8th enqueue is accepted (count=8, no error); a 9th sets Overflow_ERR=1 with count still 8.
3. Full queue, Enq_Valid_IN and Deq_Ready_IN both pulsed -> count stays 8, head advances by one, the new entry lands at the wrapped tail slot 0, and a 16-entry sequence dequeues in order across the wrap.
4. Queue holding 5 entries, Flush_IN=1 together with Enq_Valid_IN=1 and Deq_Ready_IN=1 -> next cycle Count_OUT=0, Valid_OUT=0, Instr1_OUT=0; an enqueue of PC 0x00400000 afterwards appears at the head.
5. Empty queue with Deq_Ready_IN=1 held -> count stays 0; an enqueue then becomes visible the next cycle and is dequeued on the following edge (count returns to 0).
6. Queue holding 4 entries with Overflow_ERR=1, RESET pulsed low between clock edges -> all outputs are 0 immediately, Overflow_ERR=0, Count_OUT=0.
